// File: rtl/seg14_pkg.sv
// rtl/seg14_pkg.sv - character codes, 14-segment patterns and FSM states for msg_scroll14
//
// Segment bit order (bit 13 down to bit 0), matching the display multiplexer:
//   a b c d e f g1 g2 h j k l m n
//   h = upper-left diagonal, j = upper centre vertical, k = upper-right diagonal,
//   l = lower-left diagonal, m = lower centre vertical, n = lower-right diagonal.
package seg14_pkg;

  // Character codes; everything from 38 up renders blank.
  localparam logic [5:0] CH_SPACE = 6'd0;
  localparam logic [5:0] CH_A = 6'd1;
  localparam logic [5:0] CH_B = 6'd2;
  localparam logic [5:0] CH_C = 6'd3;
  localparam logic [5:0] CH_D = 6'd4;
  localparam logic [5:0] CH_E = 6'd5;
  localparam logic [5:0] CH_F = 6'd6;
  localparam logic [5:0] CH_G = 6'd7;
  localparam logic [5:0] CH_H = 6'd8;
  localparam logic [5:0] CH_I = 6'd9;
  localparam logic [5:0] CH_J = 6'd10;
  localparam logic [5:0] CH_K = 6'd11;
  localparam logic [5:0] CH_L = 6'd12;
  localparam logic [5:0] CH_M = 6'd13;
  localparam logic [5:0] CH_N = 6'd14;
  localparam logic [5:0] CH_O = 6'd15;
  localparam logic [5:0] CH_P = 6'd16;
  localparam logic [5:0] CH_Q = 6'd17;
  localparam logic [5:0] CH_R = 6'd18;
  localparam logic [5:0] CH_S = 6'd19;
  localparam logic [5:0] CH_T = 6'd20;
  localparam logic [5:0] CH_U = 6'd21;
  localparam logic [5:0] CH_V = 6'd22;
  localparam logic [5:0] CH_W = 6'd23;
  localparam logic [5:0] CH_X = 6'd24;
  localparam logic [5:0] CH_Y = 6'd25;
  localparam logic [5:0] CH_Z = 6'd26;
  localparam logic [5:0] CH_ENE = 6'd27;
  localparam logic [5:0] CH_0 = 6'd28;
  localparam logic [5:0] CH_1 = 6'd29;
  localparam logic [5:0] CH_2 = 6'd30;
  localparam logic [5:0] CH_3 = 6'd31;
  localparam logic [5:0] CH_4 = 6'd32;
  localparam logic [5:0] CH_5 = 6'd33;
  localparam logic [5:0] CH_6 = 6'd34;
  localparam logic [5:0] CH_7 = 6'd35;
  localparam logic [5:0] CH_8 = 6'd36;
  localparam logic [5:0] CH_9 = 6'd37;

  // Segment patterns                         abcdef g1g2 hjklmn
  localparam logic [13:0] SEG_BLANK = 14'b000000_00_000000;
  localparam logic [13:0] SEG_A     = 14'b111011_11_000000;
  localparam logic [13:0] SEG_B     = 14'b111100_01_010010;
  localparam logic [13:0] SEG_C     = 14'b100111_00_000000;
  localparam logic [13:0] SEG_D     = 14'b111100_00_010010;
  localparam logic [13:0] SEG_E     = 14'b100111_10_000000;
  localparam logic [13:0] SEG_F     = 14'b100011_10_000000;
  localparam logic [13:0] SEG_G     = 14'b101111_01_000000;
  localparam logic [13:0] SEG_H     = 14'b011011_11_000000;
  localparam logic [13:0] SEG_I     = 14'b100100_00_010010;
  localparam logic [13:0] SEG_J     = 14'b011110_00_000000;
  localparam logic [13:0] SEG_K     = 14'b000011_10_001001;
  localparam logic [13:0] SEG_L     = 14'b000111_00_000000;
  localparam logic [13:0] SEG_M     = 14'b011011_00_101000;
  localparam logic [13:0] SEG_N     = 14'b011011_00_100001;
  localparam logic [13:0] SEG_O     = 14'b111111_00_000000;
  localparam logic [13:0] SEG_P     = 14'b110011_11_000000;
  localparam logic [13:0] SEG_Q     = 14'b111111_00_000001;
  localparam logic [13:0] SEG_R     = 14'b110011_11_000001;
  localparam logic [13:0] SEG_S     = 14'b101101_11_000000;
  localparam logic [13:0] SEG_T     = 14'b100000_00_010010;
  localparam logic [13:0] SEG_U     = 14'b011111_00_000000;
  localparam logic [13:0] SEG_V     = 14'b000011_00_001100;
  localparam logic [13:0] SEG_W     = 14'b011011_00_000101;
  localparam logic [13:0] SEG_X     = 14'b000000_00_101101;
  localparam logic [13:0] SEG_Y     = 14'b000000_00_101010;
  localparam logic [13:0] SEG_Z     = 14'b100100_00_001100;
  // N with the top bar standing in for the tilde.
  localparam logic [13:0] SEG_ENE   = 14'b111011_00_100001;
  localparam logic [13:0] SEG_0     = 14'b111111_00_001100;
  localparam logic [13:0] SEG_1     = 14'b011000_00_001000;
  localparam logic [13:0] SEG_2     = 14'b110110_11_000000;
  localparam logic [13:0] SEG_3     = 14'b111100_01_000000;
  localparam logic [13:0] SEG_4     = 14'b011001_11_000000;
  localparam logic [13:0] SEG_5     = 14'b101101_11_000000;
  localparam logic [13:0] SEG_6     = 14'b101111_11_000000;
  localparam logic [13:0] SEG_7     = 14'b111000_00_000000;
  localparam logic [13:0] SEG_8     = 14'b111111_11_000000;
  localparam logic [13:0] SEG_9     = 14'b111101_11_000000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    SHOW  = 2'd2
  } state_e;

endpackage

// File: rtl/seg14_font.sv
// rtl/seg14_font.sv - combinational character-code to 14-segment pattern lookup
//
// Ports:
//   code  in   6   character code
//   seg   out  14  segment pattern (bit order from seg14_pkg), 0 for space/blank codes
module seg14_font
  import seg14_pkg::*;
(
  input  logic [5:0]  code,
  output logic [13:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      CH_A:    seg = SEG_A;
      CH_B:    seg = SEG_B;
      CH_C:    seg = SEG_C;
      CH_D:    seg = SEG_D;
      CH_E:    seg = SEG_E;
      CH_F:    seg = SEG_F;
      CH_G:    seg = SEG_G;
      CH_H:    seg = SEG_H;
      CH_I:    seg = SEG_I;
      CH_J:    seg = SEG_J;
      CH_K:    seg = SEG_K;
      CH_L:    seg = SEG_L;
      CH_M:    seg = SEG_M;
      CH_N:    seg = SEG_N;
      CH_O:    seg = SEG_O;
      CH_P:    seg = SEG_P;
      CH_Q:    seg = SEG_Q;
      CH_R:    seg = SEG_R;
      CH_S:    seg = SEG_S;
      CH_T:    seg = SEG_T;
      CH_U:    seg = SEG_U;
      CH_V:    seg = SEG_V;
      CH_W:    seg = SEG_W;
      CH_X:    seg = SEG_X;
      CH_Y:    seg = SEG_Y;
      CH_Z:    seg = SEG_Z;
      CH_ENE:  seg = SEG_ENE;
      CH_0:    seg = SEG_0;
      CH_1:    seg = SEG_1;
      CH_2:    seg = SEG_2;
      CH_3:    seg = SEG_3;
      CH_4:    seg = SEG_4;
      CH_5:    seg = SEG_5;
      CH_6:    seg = SEG_6;
      CH_7:    seg = SEG_7;
      CH_8:    seg = SEG_8;
      CH_9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/msg_scroll14.sv
// rtl/msg_scroll14.sv - loadable, scrolling message source for the 12-digit 14-segment mux
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   wr_valid   in   1   character beat valid
//   wr_ready   out  1   buffer accepts a beat (EMPTY/LOAD)
//   wr_char    in   6   character code
//   wr_last    in   1   final character of the message
//   msg_clr    in   1   discard the message (overrides everything else)
//   scroll_en  in   1   scroll step timer runs while high
//   digit_idx  in   4   digit requested by the mux, 0 = leftmost
//   segm       out  14  pattern for the digit_idx sampled on the previous edge
//   step       out  1   one-cycle pulse when the scroll offset advances
module msg_scroll14 #(
  parameter int MSG_DEPTH = 32,
  parameter int DIGITS    = 12,
  parameter int GAP       = 4,
  parameter int STEP_DIV  = 6_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [5:0]  wr_char,
  input  logic        wr_last,
  input  logic        msg_clr,
  input  logic        scroll_en,
  input  logic [3:0]  digit_idx,
  output logic [13:0] segm,
  output logic        step
);

  import seg14_pkg::*;

  localparam int PW = $clog2(MSG_DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = LW + 1;
  localparam int TW = $clog2(STEP_DIV);

  localparam logic [PW-1:0] LAST_PTR  = PW'(MSG_DEPTH - 1);
  localparam logic [LW-1:0] DIGITS_L  = LW'(DIGITS);
  localparam logic [LW-1:0] GAP_L     = LW'(GAP);
  localparam logic [SW-1:0] DIGITS_S  = SW'(DIGITS);
  localparam logic [TW-1:0] TIMER_MAX = TW'(STEP_DIV - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   offset_q, offset_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            step_q, step_d;
  logic [13:0]     segm_q, segm_d;

  logic [5:0]      msg_mem_q [MSG_DEPTH];
  logic            mem_we;
  logic [PW-1:0]   mem_waddr;

  logic            accept;
  logic            commit;
  logic            scrolling;
  logic [LW-1:0]   tape_len;

  logic [SW-1:0]   idx_ext;
  logic [SW-1:0]   pos_sum;
  logic [SW-1:0]   pos;
  logic            char_vis;
  logic [5:0]      font_code;
  logic [13:0]     font_seg;

  // ---------------------------------------------------------------- control
  // A beat coinciding with msg_clr is dropped, so it never counts as accepted.
  assign accept    = wr_valid && wr_ready && !msg_clr;
  assign commit    = accept && ((state_q == EMPTY && wr_last) ||
                                (state_q == LOAD && (wr_last || ptr_q == LAST_PTR)));
  assign scrolling = (state_q == SHOW) && (len_q > DIGITS_L);
  assign tape_len  = len_q + GAP_L;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (msg_clr) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = commit ? SHOW : LOAD;
        LOAD:    if (commit) state_d = SHOW;
        SHOW:    state_d = SHOW;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    wr_ready = (state_q != SHOW);
  end

  // ------------------------------------------------------- pointer / scroll
  always_comb begin
    ptr_d     = ptr_q;
    len_d     = len_q;
    offset_d  = offset_q;
    timer_d   = timer_q;
    step_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = (state_q == EMPTY) ? '0 : ptr_q;

    if (msg_clr) begin
      ptr_d    = '0;
      len_d    = '0;
      offset_d = '0;
      timer_d  = '0;
    end else if (accept) begin
      mem_we = 1'b1;
      ptr_d  = mem_waddr + PW'(1);
      if (commit) begin
        len_d    = {1'b0, mem_waddr} + LW'(1);
        offset_d = '0;
        timer_d  = '0;
      end
    end else if (scrolling && scroll_en) begin
      if (timer_q == TIMER_MAX) begin
        timer_d  = '0;
        step_d   = 1'b1;
        offset_d = (offset_q == tape_len - LW'(1)) ? '0 : offset_q + LW'(1);
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      len_q    <= '0;
      offset_q <= '0;
      timer_q  <= '0;
      step_q   <= 1'b0;
      segm_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      offset_q <= offset_d;
      timer_q  <= timer_d;
      step_q   <= step_d;
      segm_q   <= segm_d;
    end
  end

  // Message storage needs no reset: nothing is shown until len covers it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      msg_mem_q[mem_waddr] <= wr_char;
    end
  end

  // --------------------------------------------------------------- readout
  // offset < T and digit < DIGITS < len < T, so one conditional subtract
  // folds the tape position back into range.
  always_comb begin
    idx_ext  = SW'(digit_idx);
    pos_sum  = {1'b0, offset_q} + idx_ext;
    pos      = (scrolling && pos_sum >= {1'b0, tape_len}) ? pos_sum - {1'b0, tape_len}
                                                         : pos_sum;
    char_vis = (state_q == SHOW) && (idx_ext < DIGITS_S) && (pos < {1'b0, len_q});
    font_code = char_vis ? msg_mem_q[pos[PW-1:0]] : CH_SPACE;
    segm_d   = font_seg;
  end

  seg14_font u_font (
    .code (font_code),
    .seg  (font_seg)
  );

  assign segm = segm_q;
  assign step = step_q;

endmodule

// File: tb/tb_msg_scroll14.sv
// tb/tb_msg_scroll14.sv - scoreboard bench for msg_scroll14
module tb_msg_scroll14;

  localparam int STEP = 4;

  localparam logic [13:0] P_A = 14'b11101111000000;
  localparam logic [13:0] P_B = 14'b11110001010010;
  localparam logic [13:0] P_C = 14'b10011100000000;
  localparam logic [13:0] P_E = 14'b10011110000000;
  localparam logic [13:0] P_F = 14'b10001110000000;
  localparam logic [13:0] P_I = 14'b10010000010010;
  localparam logic [13:0] P_L = 14'b00011100000000;
  localparam logic [13:0] P_N = 14'b01101100100001;
  localparam logic [13:0] P_0 = 14'b00000000000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [5:0]  wr_char = '0;
  logic        wr_last = 1'b0;
  logic        msg_clr = 1'b0;
  logic        scroll_en = 1'b0;
  logic [3:0]  digit_idx = '0;
  logic [13:0] segm;
  logic        step;

  always #5 clk = ~clk;

  msg_scroll14 #(
    .MSG_DEPTH (32),
    .DIGITS    (12),
    .GAP       (4),
    .STEP_DIV  (STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_char   (wr_char),
    .wr_last   (wr_last),
    .msg_clr   (msg_clr),
    .scroll_en (scroll_en),
    .digit_idx (digit_idx),
    .segm      (segm),
    .step      (step)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int step_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [13:0] exp;
  } exp_t;

  exp_t exp_q[$];
  logic due = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    due <= (exp_q.size() > 0);
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (step) step_seen <= step_seen + 1;
    if (due && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, {18'b0, segm}, {18'b0, e.exp});
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    msg_clr  = 1'b0;
  endtask

  task automatic beat(input logic [5:0] c, input logic last);
    sync();
    wr_valid = 1'b1;
    wr_char  = c;
    wr_last  = last;
  endtask

  task automatic clear();
    sync();
    msg_clr = 1'b1;
  endtask

  task automatic req(input string tag, input logic [3:0] idx, input logic [13:0] exp);
    exp_t e;
    sync();
    digit_idx = idx;
    e.tag = tag;
    e.exp = exp;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_step(output int at);
    logic found;
    found = 1'b0;
    at = -1;
    for (int k = 0; k < 64; k++) begin
      sync();
      if (step) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
    if (!found) chk("step_timeout", 0, 1);
  endtask

  task automatic load_alpha(input int n);
    for (int c = 1; c <= n; c++) beat(6'(c), c == n);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t1, t2, t0, acc, first_block;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", wr_ready, 1);
    chk("rst_step", step, 0);
    chk("rst_segm", segm, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) req("rst_blank", 4'(i), P_0);
    drain();
    chk("rst_ready_after", wr_ready, 1);

    // static message ELBI
    scroll_en = 1'b1;
    beat(6'd5, 1'b0);
    beat(6'd12, 1'b0);
    chk("load_ready", wr_ready, 1);
    beat(6'd2, 1'b0);
    beat(6'd9, 1'b1);
    req("elbi_d0", 4'd0, P_E);
    chk("show_ready", wr_ready, 0);
    req("elbi_d1", 4'd1, P_L);
    req("elbi_d2", 4'd2, P_B);
    req("elbi_d3", 4'd3, P_I);
    req("elbi_d4", 4'd4, P_0);
    req("elbi_d11", 4'd11, P_0);
    req("elbi_d12", 4'd12, P_0);
    req("elbi_d15", 4'd15, P_0);
    drain();
    beat(6'd1, 1'b1);
    req("show_ignores_beat", 4'd0, P_E);
    drain();
    repeat (10) sync();
    chk("static_no_step", step_seen, 0);

    // 14-char scroll A..N
    clear();
    scroll_en = 1'b0;
    load_alpha(14);
    req("scr_d0_init", 4'd0, P_A);
    req("scr_d13", 4'd13, P_0);
    drain();
    sync();
    scroll_en = 1'b1;
    t0 = cyc;
    wait_step(t1);
    chk("first_step_delay", t1 - t0, STEP);
    wait_step(t2);
    chk("step_period", t2 - t1, STEP);
    scroll_en = 1'b0;
    req("scr2_d0", 4'd0, P_C);
    req("scr2_d11", 4'd11, P_N);
    drain();
    repeat (8) sync();
    chk("frozen_steps", step_seen, 2);
    sync();
    scroll_en = 1'b1;
    repeat (15) wait_step(t1);
    scroll_en = 1'b0;
    req("scr17_d0", 4'd0, P_0);
    req("scr17_d1", 4'd1, P_A);
    req("scr17_d3", 4'd3, P_C);
    drain();
    sync();
    scroll_en = 1'b1;
    wait_step(t1);
    scroll_en = 1'b0;
    req("scr18_d0", 4'd0, P_A);
    drain();
    chk("steps_total", step_seen, 18);

    // overflow: 33 beats, no wr_last
    clear();
    acc = 0;
    first_block = -1;
    for (int i = 0; i < 33; i++) begin
      sync();
      if (!wr_ready && first_block < 0) first_block = i;
      if (wr_ready) acc++;
      wr_valid = 1'b1;
      wr_char  = 6'((i % 26) + 1);
    end
    sync();
    chk("ovf_accepted", acc, 32);
    chk("ovf_block_at", first_block, 32);
    chk("ovf_ready", wr_ready, 0);
    req("ovf_d0", 4'd0, P_A);
    req("ovf_d11", 4'd11, P_L);
    drain();
    sync();
    scroll_en = 1'b1;
    repeat (31) wait_step(t1);
    scroll_en = 1'b0;
    req("ovf31_d0", 4'd0, P_F);
    req("ovf31_d1", 4'd1, P_0);
    req("ovf31_d5", 4'd5, P_A);
    drain();

    // msg_clr during LOAD with a simultaneous beat
    clear();
    beat(6'd1, 1'b0);
    beat(6'd2, 1'b0);
    sync();
    msg_clr  = 1'b1;
    wr_valid = 1'b1;
    wr_char  = 6'd24;
    wr_last  = 1'b1;
    sync();
    chk("clr_ready", wr_ready, 1);
    req("clr_d0", 4'd0, P_0);
    req("clr_d1", 4'd1, P_0);
    drain();
    beat(6'd5, 1'b1);
    req("clr_reload_d0", 4'd0, P_E);
    req("clr_reload_d1", 4'd1, P_0);
    drain();

    // reset mid-scroll
    clear();
    load_alpha(14);
    sync();
    digit_idx = 4'd0;
    scroll_en = 1'b1;
    wait_step(t1);
    wait_step(t1);
    sync();
    scroll_en = 1'b0;
    sync();
    scroll_en = 1'b1;
    wait_step(t1);
    rst_n = 1'b0;
    #1;
    chk("midrst_segm", segm, 0);
    chk("midrst_step", step, 0);
    chk("midrst_ready", wr_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_hold_segm", segm, 0);
    rst_n = 1'b1;
    scroll_en = 1'b0;
    load_alpha(14);
    req("postrst_d0", 4'd0, P_A);
    req("postrst_d2", 4'd2, P_C);
    drain();
    sync();
    scroll_en = 1'b1;
    t0 = cyc;
    wait_step(t1);
    chk("postrst_first_step", t1 - t0, STEP);
    scroll_en = 1'b0;
    req("postrst_step1_d0", 4'd0, P_B);
    drain();

    repeat (3) sync();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
